// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, control states and flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_INC   = 4'd2,
    OP_DEC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_MOV   = 4'd8,
    OP_LDI   = 4'd9,
    OP_PASSA = 4'd10,
    OP_PASSB = 4'd11,
    OP_SHL   = 4'd12,
    OP_SHR   = 4'd13,
    OP_MUL   = 4'd14,
    OP_ADC   = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } flags_t;

  // Ops that are candidates for the iterative datapath.
  function automatic logic is_iter_op(op_t o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply and bit-serial shifts, one step per
// enabled cycle, with a step counter and a done strobe on the final step.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  op_t              kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_next,
  output logic             cout_next,
  output logic             cout_upd
);

  localparam int unsigned S  = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mcand_n;
  logic [WIDTH-1:0] mplier_n;
  logic [CW-1:0]    cnt;
  op_t              kind_q;

  // One step of the selected operation; the top samples these values on the
  // final step so the result is registered in the same edge that ends BUSY.
  always_comb begin
    res_next  = acc;
    cout_next = 1'b0;
    mcand_n   = mcand;
    mplier_n  = mplier;
    case (kind_q)
      OP_MUL: begin
        if (mplier[0]) res_next = acc + mcand;
        mcand_n  = {mcand[WIDTH-2:0], 1'b0};
        mplier_n = {1'b0, mplier[WIDTH-1:1]};
      end
      OP_SHL: begin
        cout_next = acc[WIDTH-1];
        res_next  = {acc[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        cout_next = acc[0];
        res_next  = {1'b0, acc[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  assign done     = step && (cnt == CW'(1));
  assign cout_upd = (kind_q != OP_MUL);

  // Operand capture on start, then one iteration per step while count remains.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      kind_q <= OP_ADD;
    end else if (start) begin
      acc    <= (kind == OP_MUL) ? '0 : a;
      mcand  <= a;
      mplier <= b;
      cnt    <= (kind == OP_MUL) ? CW'(WIDTH) : CW'(b[S-1:0]);
      kind_q <= kind;
    end else if (step && (cnt != '0)) begin
      acc    <= res_next;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready operation intake, single-cycle ops computed
// here, multiply/shift delegated to alu_iter, registered result and flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned S = $clog2(WIDTH);

  state_t           state, nxt;
  op_t              opc;
  logic             accept;
  logic             iter_go;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic [WIDTH-1:0] sc_res;
  flags_t           sc_flags;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             arith;
  logic [WIDTH:0]   sum;

  logic             it_done;
  logic [WIDTH-1:0] it_res;
  logic             it_cout;
  logic             it_cout_upd;
  flags_t           it_flags;

  assign opc       = op_t'(op);
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  // A zero-count shift has nothing to iterate and completes like a single-cycle op.
  assign iter_go   = accept && is_iter_op(opc) &&
                     ((opc == OP_MUL) || (b[S-1:0] != '0));
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (iter_go),
    .step      (state == BUSY),
    .kind      (opc),
    .a         (a),
    .b         (b),
    .done      (it_done),
    .res_next  (it_res),
    .cout_next (it_cout),
    .cout_upd  (it_cout_upd)
  );

  // Single-cycle result and flags; add/sub family share one WIDTH+1 adder.
  always_comb begin
    sc_res         = '0;
    sc_flags       = '0;
    sc_flags.carry = flags_q.carry;
    y              = '0;
    cin            = 1'b0;
    sub            = 1'b0;
    arith          = 1'b0;
    sum            = '0;
    case (opc)
      OP_ADD:   begin arith = 1'b1; y = b; end
      OP_ADC:   begin arith = 1'b1; y = b; cin = flags_q.carry; end
      OP_INC:   begin arith = 1'b1; y = WIDTH'(1); end
      OP_SUB:   begin arith = 1'b1; y = b; sub = 1'b1; end
      OP_DEC:   begin arith = 1'b1; y = WIDTH'(1); sub = 1'b1; end
      OP_AND:   sc_res = a & b;
      OP_OR:    sc_res = a | b;
      OP_XOR:   sc_res = a ^ b;
      OP_NOT:   sc_res = ~a;
      OP_MOV:   sc_res = b;
      OP_LDI:   sc_res = imm;
      OP_PASSA: sc_res = a;
      OP_PASSB: sc_res = b;
      OP_SHL, OP_SHR: begin
        sc_res         = a;
        sc_flags.carry = 1'b0;
      end
      default:  sc_res = '0;
    endcase
    if (arith) begin
      if (sub) sum = {1'b0, a} - {1'b0, y};
      else     sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      sc_res         = sum[WIDTH-1:0];
      sc_flags.carry = sum[WIDTH];
      if (sub) sc_flags.ovf = (a[WIDTH-1] != y[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      else     sc_flags.ovf = (a[WIDTH-1] == y[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
    end
    sc_flags.zero = (sc_res == '0);
    sc_flags.neg  = sc_res[WIDTH-1];
  end

  // Flags for an iterative op finishing this cycle; MUL keeps the old carry.
  always_comb begin
    it_flags       = '0;
    it_flags.zero  = (it_res == '0);
    it_flags.neg   = it_res[WIDTH-1];
    it_flags.carry = it_cout_upd ? it_cout : flags_q.carry;
  end

  // Next-state logic for the IDLE/BUSY/DONE handshake sequencer.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = iter_go ? BUSY : DONE;
      BUSY:    if (it_done) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, result and flag registers; results only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state <= nxt;
      if (accept && !iter_go) begin
        result_q <= sc_res;
        flags_q  <= sc_flags;
      end else if (it_done) begin
        result_q <= it_res;
        flags_q  <= it_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (WIDTH=8) with hand-written
// sequences for reset during multiply and output back-pressure.
module tb_alu_mc;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a, b, imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero, carry, neg, ovf;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [7:0] res;
    logic [3:0] fl;   // {zero, carry, neg, ovf}
    int         lat;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE (called just after a rising edge), wait for
  // out_valid with a cycle budget, capture outputs, then complete the handshake.
  task automatic run_op(input logic [3:0] top, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [7:0] timm, output logic [7:0] r, output logic [3:0] f,
                        output int lat, output logic rdy_low);
    in_valid = 1'b1; op = top; a = ta; b = tb_; imm = timm;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'h0; a = ~ta; b = ~tb_; imm = ~timm;
    lat = 1;
    rdy_low = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_low = 1'b0;
    r = result;
    f = {zero, carry, neg, ovf};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [3:0] f;
    int         lat;
    logic       rl;
    logic       stable;

    //           op        a      b      imm    res    zcnv   lat
    vt[0]  = '{OP_ADD,   8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 1};
    vt[1]  = '{OP_ADC,   8'h00, 8'h00, 8'h00, 8'h01, 4'b0000, 1};
    vt[2]  = '{OP_SUB,   8'h80, 8'h01, 8'h00, 8'h7F, 4'b0001, 1};
    vt[3]  = '{OP_SUB,   8'h00, 8'h01, 8'h00, 8'hFF, 4'b0110, 1};
    vt[4]  = '{OP_MUL,   8'h0F, 8'h11, 8'h00, 8'hFF, 4'b0110, 9};
    vt[5]  = '{OP_SHL,   8'h81, 8'h09, 8'h00, 8'h02, 4'b0100, 2};
    vt[6]  = '{OP_ADD,   8'h00, 8'h00, 8'h00, 8'h00, 4'b1000, 1};
    vt[7]  = '{OP_SHR,   8'h81, 8'h00, 8'h00, 8'h81, 4'b0010, 1};
    vt[8]  = '{OP_INC,   8'h7F, 8'h00, 8'h00, 8'h80, 4'b0011, 1};
    vt[9]  = '{OP_DEC,   8'h00, 8'h00, 8'h00, 8'hFF, 4'b0110, 1};
    vt[10] = '{OP_AND,   8'hF0, 8'h3C, 8'h00, 8'h30, 4'b0100, 1};
    vt[11] = '{OP_OR,    8'h0F, 8'h30, 8'h00, 8'h3F, 4'b0100, 1};
    vt[12] = '{OP_XOR,   8'hFF, 8'hFF, 8'h00, 8'h00, 4'b1100, 1};
    vt[13] = '{OP_NOT,   8'h0F, 8'h00, 8'h00, 8'hF0, 4'b0110, 1};
    vt[14] = '{OP_MOV,   8'h55, 8'h00, 8'h00, 8'h00, 4'b1100, 1};
    vt[15] = '{OP_LDI,   8'h00, 8'h00, 8'h5A, 8'h5A, 4'b0100, 1};
    vt[16] = '{OP_PASSA, 8'h80, 8'h00, 8'h00, 8'h80, 4'b0110, 1};
    vt[17] = '{OP_PASSB, 8'h80, 8'h01, 8'h00, 8'h01, 4'b0100, 1};
    vt[18] = '{OP_SHR,   8'h81, 8'h03, 8'h00, 8'h10, 4'b0000, 4};
    vt[19] = '{OP_SHL,   8'h03, 8'h07, 8'h00, 8'h80, 4'b0110, 8};
    vt[20] = '{OP_MUL,   8'h10, 8'h10, 8'h00, 8'h00, 4'b1100, 9};
    vt[21] = '{OP_ADC,   8'hFF, 8'h00, 8'h00, 8'h00, 4'b1100, 1};
    vt[22] = '{OP_ADD,   8'h7F, 8'h01, 8'h00, 8'h80, 4'b0011, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; a = 8'h00; b = 8'h00; imm = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, 8'h00);
    chk("reset_flags", {zero, carry, neg, ovf}, 4'b0000);
    chk("reset_in_ready_in_rst", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 23; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, r, f, lat, rl);
      chk($sformatf("vec%0d_result", i), r, vt[i].res);
      chk($sformatf("vec%0d_flags", i), f, vt[i].fl);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_in_ready_low", i), rl, 1'b1);
      chk($sformatf("vec%0d_back_to_idle", i), {out_valid, in_ready}, 2'b01);
    end

    // Reset during the third BUSY cycle of MUL 7*9 must discard the op.
    in_valid = 1'b1; op = OP_MUL; a = 8'd7; b = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midmul_rst_out_valid", out_valid, 1'b0);
    chk("midmul_rst_result", result, 8'h00);
    chk("midmul_rst_flags", {zero, carry, neg, ovf}, 4'b0000);
    rst = 1'b0;
    #1;
    chk("midmul_rst_in_ready", in_ready, 1'b1);
    stable = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) stable = 1'b0;
    end
    chk("midmul_rst_no_stray_done", stable, 1'b1);

    // Back-pressure: result held while out_ready stays low; new requests ignored.
    in_valid = 1'b1; op = OP_LDI; a = 8'h11; b = 8'h22; imm = 8'h5A;
    @(posedge clk); #1;
    op = OP_ADD; a = 8'h01; b = 8'h01; imm = 8'h00;
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_result", result, 8'h5A);
    chk("bp_flags", {zero, carry, neg, ovf}, 4'b0000);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (result !== 8'h5A || {zero, carry, neg, ovf} !== 4'b0000 ||
          in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable_5_cycles", stable, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready, result}, {1'b0, 1'b1, 8'h5A});

    run_op(OP_ADD, 8'h01, 8'h02, 8'h00, r, f, lat, rl);
    chk("post_bp_result", r, 8'h03);
    chk("post_bp_flags", f, 4'b0000);
    chk("post_bp_latency", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
